sram_rd_sender: RTL

- Transmitter end of the SIMD SRAM read-data channel (sramrd0/sramrd1).
- Accepts read-address requests over rdy/ack.
- Drives a 1-cycle-latency SRAM read port and buffers the returned vectors in a 2-entry output queue.
- Presents those vectors to the SIMD ALU over rdy/ack, sustaining one vector per cycle with no data loss under backpressure.
- One instance per ALU read channel.

---
 rtl/sram_rd_sender.sv | 71 +++++++
 1 files changed

// File: rtl/sram_rd_sender.sv
// sram_rd_sender: SRAM read-data channel transmitter with a 2-entry output queue.
// Define SRAM_RD_SENDER_TAG_EN to carry a per-vector tag bit alongside the data.
module sram_rd_sender #(
  parameter int DBW      = 16,
  parameter int VSIZE    = 32,
  parameter int NWORD    = 512,
  parameter int SRAM_ABW = $clog2(NWORD)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 req_rdy,
  output logic                 req_ack,
  input  logic [SRAM_ABW-1:0]  i_raddr,
  output logic                 o_sram_re,
  output logic [SRAM_ABW-1:0]  o_sram_raddr,
  input  logic [DBW*VSIZE-1:0] i_sram_rdata,
  output logic                 sramrd_rdy,
  input  logic                 sramrd_ack,
  output logic [DBW-1:0]       o_sramrd [VSIZE]
`ifdef SRAM_RD_SENDER_TAG_EN
  ,
  input  logic                 i_rtag,
  output logic                 o_sramrd_tag
`endif
);
  logic                 r_inflight, r_head, r_tail;
  logic [1:0]           r_cnt;
  logic [DBW*VSIZE-1:0] r_mem [2];
  logic                 w_pop, w_push;
  assign w_pop        = sramrd_rdy && sramrd_ack;
  assign w_push       = r_inflight;
  // A pop this cycle frees a slot, so streaming never stalls the request side.
  assign req_ack      = req_rdy && ({1'b0, r_cnt} + {2'b0, r_inflight} < 3'd2 + {2'b0, w_pop});
  assign o_sram_re    = req_ack;
  assign o_sram_raddr = i_raddr;
  assign sramrd_rdy   = r_cnt != 2'd0;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= req_ack;
      if (w_push) r_tail <= ~r_tail;
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= i_sram_rdata;
  end
  for (genvar l = 0; l < VSIZE; l++) begin : g_lane
    assign o_sramrd[l] = r_mem[r_head][l*DBW +: DBW];
  end
`ifdef SRAM_RD_SENDER_TAG_EN
  logic r_inflight_tag;
  logic r_tag [2];
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_inflight_tag <= 1'b0;
      r_tag[0]       <= 1'b0;
      r_tag[1]       <= 1'b0;
    end else begin
      r_inflight_tag <= i_rtag;
      if (w_push) r_tag[r_tail] <= r_inflight_tag;
    end
  end
  assign o_sramrd_tag = r_tag[r_head];
`endif
endmodule
